// File: rtl/gh_round_subs_fold.sv
// gh_round_subs_fold
//
// Folded GOST R 34.11/34.12 byte-substitution stage. It accepts one DATA_W-bit
// state word and substitutes LANES bytes per clock through the pi table (or its
// inverse), then presents the finished word. This trades throughput for area:
// only LANES S-box ROM instances are built, whatever the word width.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   clken      global advance enable; 0 freezes all state and blocks handshakes
//   in_valid   input word valid
//   in_ready   input accepted on in_valid && in_ready (combinational)
//   in_data    state word, byte i = in_data[8i+7:8i]
//   in_inv     sampled with in_data: 0 = pi, 1 = pi^-1
//   out_valid  result valid (state == DONE)
//   out_ready  downstream accept; transfer on out_valid && out_ready && clken
//   out_data   work register, always driven
module gh_round_subs_fold #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned LANES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BEATS  = BYTES / LANES;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LANE_W = 8 * LANES;

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16,
    8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA,
    8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21,
    8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0,
    8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB,
    8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12,
    8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7,
    8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E,
    8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9,
    8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC,
    8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44,
    8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F,
    8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7,
    8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE,
    8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B,
    8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0,
    8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Inverse ROM derived from PI at elaboration so the two can never disagree.
  function automatic logic [255:0][7:0] invert_pi();
    logic [255:0][7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      r[PI[i]] = 8'(i);
    end
    return r;
  endfunction

  localparam logic [255:0][7:0] PI_INV = invert_pi();

  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    return inv ? PI_INV[b] : PI[b];
  endfunction

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   beat_q;
  logic               mode_q;
  logic [DATA_W-1:0]  work_q;

  logic [LANE_W-1:0]  slice_in;
  logic [LANE_W-1:0]  slice_out;
  logic [DATA_W-1:0]  work_sub;
  logic               accept;

  assign in_ready  = !rst && clken &&
                     ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign out_data  = work_q;

  // Only the current beat's LANES bytes pass through the S-boxes.
  always_comb begin
    slice_in  = work_q[beat_q*LANE_W +: LANE_W];
    slice_out = '0;
    for (int l = 0; l < LANES; l++) begin
      slice_out[l*8 +: 8] = sbox(slice_in[l*8 +: 8], mode_q);
    end
    work_sub = work_q;
    work_sub[beat_q*LANE_W +: LANE_W] = slice_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      mode_q  <= 1'b0;
      work_q  <= '0;
    end else if (clken) begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            work_q  <= in_data;
            mode_q  <= in_inv;
            beat_q  <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          work_q <= work_sub;
          if (beat_q == CNT_W'(BEATS - 1)) begin
            beat_q  <= '0;
            state_q <= StDone;
          end else begin
            beat_q <= beat_q + CNT_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            // Output transfer; a simultaneous accept goes straight back to BUSY.
            if (accept) begin
              work_q  <= in_data;
              mode_q  <= in_inv;
              beat_q  <= '0;
              state_q <= StBusy;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gh_round_subs_fold.sv
module tb_gh_round_subs_fold;

  localparam int unsigned W = 512;

  logic         clk = 1'b0;
  logic         rst;
  logic         clken;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_inv;
  logic         out_ready;

  logic         rdy0, rdy1, rdy2;
  logic         ov0, ov1, ov2;
  logic [W-1:0] od0, od1, od2;

  int checks = 0;
  int errors = 0;

  logic [7:0] pi_t [256];
  logic [7:0] pinv_t [256];

  always #5 clk = ~clk;

  gh_round_subs_fold u_dut (
    .clk(clk), .rst(rst), .clken(clken), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_inv(in_inv), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0)
  );

  gh_round_subs_fold #(.DATA_W(512), .LANES(64)) u_dut_b1 (
    .clk(clk), .rst(rst), .clken(clken), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_inv(in_inv), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1)
  );

  gh_round_subs_fold #(.DATA_W(512), .LANES(1)) u_dut_b64 (
    .clk(clk), .rst(rst), .clken(clken), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .in_inv(in_inv), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2)
  );

  initial begin
    logic [7:0] t [256] = '{
      8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA,
      8'h23, 8'hC5, 8'h04, 8'h4D, 8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA,
      8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1, 8'hF9, 8'h18, 8'h65, 8'h5A,
      8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
      8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98,
      8'h7F, 8'hD4, 8'hD3, 8'h1F, 8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB,
      8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC, 8'hB5, 8'h70, 8'h0E, 8'h56,
      8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
      8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F,
      8'h9D, 8'h9E, 8'hB2, 8'hB1, 8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E,
      8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57, 8'hDF, 8'hF5, 8'h24, 8'hA9,
      8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
      8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50,
      8'h4E, 8'h33, 8'h0A, 8'h4A, 8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44,
      8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41, 8'hAD, 8'h45, 8'h46, 8'h92,
      8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
      8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4,
      8'h88, 8'hD9, 8'hE7, 8'h89, 8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE,
      8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61, 8'h20, 8'h71, 8'h67, 8'hA4,
      8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
      8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2,
      8'h39, 8'h4B, 8'h63, 8'hB6
    };
    for (int i = 0; i < 256; i++) begin
      pi_t[i] = t[i];
      pinv_t[t[i]] = 8'(i);
    end
  end

  // Reference: the whole word mapped bytewise, independent of folding.
  function automatic logic [W-1:0] ref_sub(input logic [W-1:0] w, input logic inv);
    logic [W-1:0] r;
    for (int i = 0; i < W / 8; i++) begin
      r[i*8 +: 8] = inv ? pinv_t[w[i*8 +: 8]] : pi_t[w[i*8 +: 8]];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one word from IDLE, scramble the inputs, and count cycles to out_valid.
  task automatic send_word(input logic [W-1:0] d, input logic inv, output int lat);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    step();
    in_valid = 1'b0;
    in_data  = rand_word();
    in_inv   = ~inv;
    lat = 1;
    while (!ov0 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clken = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov0); end
    checks++;
    if (od0 !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", od0); end
    checks++;
    if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", rdy0); end
    rst = 1'b0;
    step();
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", rdy0); end
  endtask

  task automatic test_forward_zero();
    int lat;
    send_word('0, 1'b0, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL zero_latency got %0d want 5", lat); end
    checks++;
    if (od0 !== {64{8'hFC}}) begin
      errors++; $display("FAIL zero_data got %h want all FC", od0);
    end
    drain();
  endtask

  task automatic test_ramp();
    logic [W-1:0] ramp, fwd;
    int lat;
    for (int i = 0; i < 64; i++) ramp[i*8 +: 8] = 8'(i);
    send_word(ramp, 1'b0, lat);
    fwd = od0;
    checks++;
    if (fwd[7:0] !== 8'hFC) begin errors++; $display("FAIL ramp_b0 got %h want fc", fwd[7:0]); end
    checks++;
    if (fwd[15:8] !== 8'hEE) begin errors++; $display("FAIL ramp_b1 got %h want ee", fwd[15:8]); end
    checks++;
    if (fwd[511:504] !== 8'h1F) begin
      errors++; $display("FAIL ramp_b63 got %h want 1f", fwd[511:504]);
    end
    checks++;
    if (fwd !== ref_sub(ramp, 1'b0)) begin
      errors++; $display("FAIL ramp_fwd got %h want %h", fwd, ref_sub(ramp, 1'b0));
    end
    drain();
    send_word(fwd, 1'b1, lat);
    checks++;
    if (od0 !== ramp) begin errors++; $display("FAIL ramp_inv got %h want %h", od0, ramp); end
    drain();
    send_word({64{8'hFC}}, 1'b1, lat);
    checks++;
    if (od0 !== '0) begin errors++; $display("FAIL inv_fc got %h want 0", od0); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w1, w2, held;
    logic inv2;
    int lat;
    int bad;
    w1 = rand_word();
    w2 = rand_word();
    inv2 = 1'($urandom);
    send_word(w1, 1'b1, lat);
    held = od0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ov0 !== 1'b1 || od0 !== held || rdy0 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    checks++;
    if (held !== ref_sub(w1, 1'b1)) begin
      errors++; $display("FAIL bp_data got %h want %h", held, ref_sub(w1, 1'b1));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w2;
    in_inv    = inv2;
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_ready got %b want 1", rdy0); end
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL bp_transfer got %b want 0", ov0); end
    lat = 1;
    while (!ov0 && lat < 200) begin
      in_inv  = ~in_inv;
      in_data = rand_word();
      step();
      lat++;
    end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL bp_latency got %0d want 5", lat); end
    checks++;
    if (od0 !== ref_sub(w2, inv2)) begin
      errors++; $display("FAIL bp_result got %h want %h", od0, ref_sub(w2, inv2));
    end
    drain();
  endtask

  task automatic test_stall();
    logic [W-1:0] w;
    int lat;
    w = rand_word();
    in_valid = 1'b1; in_data = w; in_inv = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 1;
    step(); lat++;
    clken = 1'b0;
    for (int c = 0; c < 3; c++) begin step(); lat++; end
    clken = 1'b1;
    while (!ov0 && lat < 200) begin step(); lat++; end
    checks++;
    if (lat != 8) begin errors++; $display("FAIL stall_latency got %0d want 8", lat); end
    checks++;
    if (od0 !== ref_sub(w, 1'b0)) begin
      errors++; $display("FAIL stall_result got %h want %h", od0, ref_sub(w, 1'b0));
    end
    clken = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (ov0 !== 1'b1) begin errors++; $display("FAIL stall_no_xfer got %b want 1", ov0); end
    clken = 1'b1; out_ready = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    int lat;
    in_valid = 1'b1; in_data = rand_word(); in_inv = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (ov0 !== 1'b0 || od0 !== '0) begin
      errors++; $display("FAIL midrst got valid %b data %h want 0/0", ov0, od0);
    end
    step();
    rst = 1'b0;
    w = rand_word();
    send_word(w, 1'b1, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL midrst_latency got %0d want 5", lat); end
    checks++;
    if (od0 !== ref_sub(w, 1'b1)) begin
      errors++; $display("FAIL midrst_result got %h want %h", od0, ref_sub(w, 1'b1));
    end
    drain();
  endtask

  task automatic test_configs();
    logic [W-1:0] w;
    logic inv;
    int n, l0, l1, l2;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int t = 0; t < 4; t++) begin
      w = rand_word();
      inv = 1'($urandom);
      in_valid = 1'b1; in_data = w; in_inv = inv;
      step();
      in_valid = 1'b0; in_data = rand_word(); in_inv = ~inv;
      n = 1; l0 = 0; l1 = 0; l2 = 0;
      while (!(ov0 && ov1 && ov2) && n < 100) begin
        step();
        n++;
        if (ov0 && l0 == 0) l0 = n;
        if (ov1 && l1 == 0) l1 = n;
        if (ov2 && l2 == 0) l2 = n;
      end
      checks++;
      if (l0 != 5 || l1 != 2 || l2 != 65) begin
        errors++; $display("FAIL cfg_latency got %0d/%0d/%0d want 5/2/65", l0, l1, l2);
      end
      checks++;
      if (od1 !== ref_sub(w, inv)) begin
        errors++; $display("FAIL cfg_b1 got %h want %h", od1, ref_sub(w, inv));
      end
      checks++;
      if (od2 !== ref_sub(w, inv)) begin
        errors++; $display("FAIL cfg_b64 got %h want %h", od2, ref_sub(w, inv));
      end
      checks++;
      if (od0 !== ref_sub(w, inv)) begin
        errors++; $display("FAIL cfg_b4 got %h want %h", od0, ref_sub(w, inv));
      end
      drain();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_forward_zero();
    test_ramp();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_configs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gh_round_subs_fold.md
# gh_round_subs_fold

Parametrised, folded GOST R 34.11/34.12 byte-substitution stage with valid/ready handshaking and a forward/inverse mode. It accepts one DATA_W-bit state word and substitutes LANES bytes per clock through the standard 256-entry pi table, or its inverse. After DATA_W/(8·LANES) beats it presents the complete result. It sits between the key/state mixing stage and the linear transform in area-constrained hash/cipher round datapaths, trading throughput for LUT count.

## Interface
- DATA_W, 512, state word width in bits; must be a multiple of 8.
- LANES, 16, bytes substituted per beat; must divide DATA_W/8. Derived: BEATS = DATA_W/(8·LANES), CNT_W = max(1, clog2(BEATS)).

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clken  in  1  global advance enable; when 0 all state is frozen and no handshake completes.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  DATA_W  state word; byte i = in_data[8i+7:8i].
- in_inv  in  1  sampled with in_data; 0 = pi, 1 = pi⁻¹.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept; transfer on out_valid && out_ready && clken.
- out_data  out  DATA_W  substituted word.

## Operation
- Tables: pi is the team's standard GOST pi table (pi[0x00]=0xFC, pi[0x01]=0xEE, pi[0xA5]=0x00, pi[0xFF]=0xB6). pi⁻¹ is its exact inverse (pi⁻¹[0xFC]=0x00, pi⁻¹[0x00]=0xA5). Both are constant ROMs.
- Storage: one DATA_W work register, substituted in place. Also a latched mode bit, a CNT_W beat counter, and a state register.
- FSM states:
  - IDLE → BUSY on accept.
  - BUSY → DONE on the clken edge that processes beat BEATS−1.
  - DONE → IDLE on output transfer without a simultaneous accept.
  - DONE → BUSY on output transfer with a simultaneous accept.
- Accept: work ← in_data, mode ← in_inv, beat ← 0.
- BUSY, each clken=1 edge: bytes beat·LANES … beat·LANES+LANES−1 of work ← table[byte], using the latched mode. Then beat ← beat+1. The counter wraps to 0 on entering DONE.
- in_ready = !rst && clken && (IDLE || (DONE && out_ready)). It is combinational, and 0 throughout BUSY.
- out_valid = (state == DONE). out_data = work register, always driven. It is meaningful only while out_valid.
- While out_valid && !out_ready, out_data and out_valid are held stable.
- in_data and in_inv are don't-care outside the accept cycle. in_inv changes never affect a word in flight.
- clken=0: state, counter, work and mode hold. in_ready=0, and out_ready is ignored (no transfer).
- Reset values: state IDLE, beat 0, mode 0, work 0. Hence out_valid=0, out_data=0, in_ready=0 while rst=1.
- Reset mid-operation: rst asserted in any state immediately clears everything to reset values. The partial word is discarded and no output is produced for it.
- BEATS=1 (LANES=DATA_W/8): full-width substitution in a single BUSY beat.

## Timing
- Latency: accept at edge E0 → out_valid high after edge E0+BEATS. That is BEATS+1 cycles from the accept cycle, assuming clken stays 1. Each clken=0 cycle adds exactly one cycle.
- Throughput with out_ready=1 and in_valid=1: one word per BEATS+1 cycles. Output transfer and next accept share the DONE cycle, with no extra bubble.
- Default DATA_W=512, LANES=16: BEATS=4, latency 5 cycles.
- out_data is registered with no combinational path from inputs. in_ready has a combinational path from out_ready, clken and rst only.

## Test plan
- Reset: rst=1 with clken=1 → out_valid=0, out_data=0, in_ready=0. Release rst → in_ready=1 on the next cycle in IDLE.
- Forward, default params, in_data=0, in_inv=0 → out_valid exactly 5 cycles after accept; every byte of out_data =0xFC.
- Forward ramp, byte i = i (0x00..0x3F) → byte0=0xFC, byte1=0xEE, byte63=0x1F. Feed the result back with in_inv=1 → returns the original ramp exactly. Also all-0xFC input with in_inv=1 → all 0x00.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid held, out_data bit-stable, in_ready=0. Then out_ready=1 with in_valid=1 → both transfers in the same cycle, next out_valid 5 cycles later. Toggle in_inv mid-BUSY → no effect on the result.
- Stall and reset: clken=0 for 3 cycles during BUSY → latency becomes 8, result unchanged. Separately, assert rst during beat 2 → out_valid=0 and out_data=0 immediately. A subsequent word completes correctly with latency 5.
- Configs LANES=64 (BEATS=1) and LANES=1 (BEATS=64) with random words and modes → results match a reference model. Latencies are 2 and 65 respectively.
